data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
// Parametrised successor data memory for the RISC-V core: byte-addressable RAM behind a req/rsp valid-ready handshake.
// - Fixed programmable access latency; XLEN 32 or 64 (adds LD/SD/LWU); detects illegal funct3 and misalignment.
// - Sits between the MEM stage/LSU and the RAM; one outstanding request at a time.
// PARAMETERS
// XLEN           32   data/address width; legal values 32 or 64
// ADDRESS_WIDTH  16   RAM is 2**ADDRESS_WIDTH bytes; addr uses A[ADDRESS_WIDTH-1:0]
// DATA_WIDTH     8    RAM cell width (bytes); fixed at 8
// LATENCY        1    cycles from request acceptance to rsp_valid; legal 1..15
// PORTS
// clk         in   1     clock, all state on rising edge
// rst_n       in   1     asynchronous active-low reset
// req_valid   in   1     request present
// req_ready   out  1     controller can accept; high only in IDLE
// req_we      in   1     1 = store, 0 = load
// req_addr    in   XLEN  byte address
// req_wdata   in   XLEN  store data, low bytes used per size
// req_funct3  in   3     RISC-V load/store funct3
// rsp_valid   out  1     response present
// rsp_ready   in   1     consumer accepts response
// rsp_rdata   out  XLEN  load result, sign/zero extended; 0 for stores and faults
// rsp_fault   out  1     access rejected (illegal funct3 or misaligned)
// BEHAVIOUR
// - Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_fault=0, latency counter 0. RAM contents not reset.
// - States IDLE -> BUSY -> RESP -> IDLE.
//   IDLE: req_valid && req_ready at edge T latches we/addr/wdata/funct3, counter=LATENCY-1, go BUSY.
//   BUSY: counter decrements; when counter==0, on that edge: perform write (if legal) or capture read, set rsp_*, go RESP.
//   Thus rsp_valid first high at edge T+LATENCY.
//   RESP: rsp_valid held with stable rsp_rdata/rsp_fault until rsp_valid && rsp_ready; then rsp_valid=0, go IDLE.
//   No new request is accepted in the same cycle as the response handshake.
// - funct3: 000 B, 001 H, 010 W, 011 D (XLEN=64 only), 100 BU, 101 HU, 110 WU (XLEN=64 only, load only).
//   Illegal funct3: 111; 011/110 when XLEN=32; 1xx on store -> rsp_fault=1, no write, rdata=0.
// - Extension: B/H/W signed loads sign-extend bit 7/15/31 to XLEN; BU/HU/WU zero-extend; D/full-width is unextended.
// - Little-endian: byte i of data at addr+i; byte addresses computed modulo 2**ADDRESS_WIDTH (top wraps to 0).
// - Store writes only size bytes; other bytes unchanged. Load issued after a store completes sees the new data.
// - Reset asserted mid-operation: pending access aborted, no RAM write, outputs to reset values immediately.
// - req_* inputs ignored outside IDLE; stores return rdata=0, fault=0 unless rejected.
// CONFIGURATION
// DMEM_MISALIGN_TRAP_EN defined:
//   - access whose addr is not a multiple of its size -> rsp_fault=1, no write, rdata=0; same latency.
// DMEM_MISALIGN_TRAP_EN undefined:
//   - misaligned accesses performed bytewise with modulo wrap, fault only for illegal funct3.
// TESTING
// 1. XLEN=32, LATENCY=1: SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_rdata=0xDEADBEEF, rsp_valid one cycle after accept.
// 2. After test 1: LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x10 -> 0xFFFFBEEF; LHU -> 0x0000BEEF.
// 3. SB 0x55 @0x11 over 0xDEADBEEF, then LW @0x10 -> 0xDEAD55EF (other bytes preserved).
// 4. LATENCY=3, rsp_ready low 4 cycles: rsp_valid at T+3, data stable while stalled, req_ready=0 until handshake+1.
// 5. SH @0x21 with macro -> rsp_fault=1, memory @0x20..0x23 unchanged; without macro, SW 0xA1B2C3D4 @0xFFFE -> LBU @0x0001 = 0xA1.
// 6. XLEN=64: SD 0x8000_0000_1234_5678 @0x40, LWU @0x44 -> 0x80000000; funct3=111 -> fault=1, rdata=0; rst_n low in BUSY -> no write.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
// Byte-addressable data RAM for the RISC-V core, behind a req/rsp valid-ready
// handshake. One request is in flight at a time. Every access takes a fixed
// LATENCY cycles from acceptance to rsp_valid.
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   : an access whose address is not a multiple of its size faults
//               (no write, rdata 0, same latency)
//   undefined : misaligned accesses are performed bytewise with address wrap
//
// Ports
//   clk          in   clock, all state on the rising edge
//   rst_n        in   asynchronous active-low reset
//   req_valid    in   request present
//   req_ready    out  controller can accept (IDLE only)
//   req_we       in   1 = store, 0 = load
//   req_addr     in   byte address (low ADDRESS_WIDTH bits used)
//   req_wdata    in   store data, low bytes used per access size
//   req_funct3   in   RISC-V load/store funct3
//   rsp_valid    out  response present
//   rsp_ready    in   consumer accepts response
//   rsp_rdata    out  load result, sign/zero extended; 0 for stores and faults
//   rsp_fault    out  access rejected (illegal funct3 or misaligned)
//
// State table
//   IDLE | waiting for a request, req_ready high
//   BUSY | latency countdown; access performed on the edge where count is 0
//   RESP | response held until rsp_valid && rsp_ready
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int XLEN          = 32,
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int LATENCY       = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [2:0]      req_funct3,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_fault
);

  localparam int NB = XLEN / DATA_WIDTH;
  localparam int IW = $clog2(XLEN);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                   state_q;
  logic                     we_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [XLEN-1:0]          wdata_q;
  logic [2:0]               funct3_q;
  logic [3:0]               cnt_q;
  logic                     rsp_valid_q;
  logic [XLEN-1:0]          rsp_rdata_q;
  logic                     rsp_fault_q;

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDRESS_WIDTH)-1];

  logic [3:0]      nbytes;
  int              nbits;
  logic [IW-1:0]   msb_idx;
  logic            fault_d;
  logic [XLEN-1:0] raw;
  logic [XLEN-1:0] rdata_d;
  logic            do_write;

  // Upper address bits are outside the RAM and intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[XLEN-1:ADDRESS_WIDTH];

  assign nbytes  = 4'd1 << funct3_q[1:0];
  assign nbits   = DATA_WIDTH * int'(nbytes);
  assign msb_idx = IW'(nbits - 1);

  always_comb begin
    fault_d = 1'b0;
    if (funct3_q == 3'b111) fault_d = 1'b1;
    if ((XLEN == 32) && ((funct3_q == 3'b011) || (funct3_q == 3'b110))) fault_d = 1'b1;
    // Unsigned variants exist only for loads.
    if (we_q && funct3_q[2]) fault_d = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((addr_q & ADDRESS_WIDTH'(nbytes - 4'd1)) != '0) fault_d = 1'b1;
`endif
  end

  // Little-endian gather with address wrap at the top of the RAM.
  always_comb begin
    raw = '0;
    for (int i = 0; i < NB; i++) begin
      raw[i*DATA_WIDTH +: DATA_WIDTH] = mem[addr_q + ADDRESS_WIDTH'(i)];
    end
  end

  // funct3[2] clear selects sign extension from the access MSB.
  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < XLEN; i++) begin
      if (i < nbits) rdata_d[i] = raw[i];
      else           rdata_d[i] = ~funct3_q[2] & raw[msb_idx];
    end
  end

  // Reset forces IDLE asynchronously, so an aborted access never writes.
  assign do_write = (state_q == S_BUSY) && (cnt_q == 4'd0) && we_q && !fault_d;

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < NB; i++) begin
        if (i < int'(nbytes)) begin
          mem[addr_q + ADDRESS_WIDTH'(i)] <= wdata_q[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      funct3_q    <= 3'b000;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            addr_q   <= req_addr[ADDRESS_WIDTH-1:0];
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
            cnt_q    <= LAT_M1;
            state_q  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt_q == 4'd0) begin
            rsp_valid_q <= 1'b1;
            rsp_fault_q <= fault_d;
            rsp_rdata_q <= (fault_d || we_q) ? '0 : rdata_d;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_fault_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Two controllers side by side: a 32-bit one with LATENCY 1 and a 64-bit one
// with LATENCY 3. A driver issues requests and pushes the reference model's
// answer; per-controller monitors pop and compare when rsp_valid rises.
module tb_data_mem_ctrl;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             rst_n;
  logic [1:0]       req_valid, req_we, rsp_ready;
  logic [1:0][63:0] req_addr, req_wdata;
  logic [1:0][2:0]  req_funct3;
  wire  [1:0]       req_ready_w, rsp_valid_w, rsp_fault_w;
  wire  [31:0]      rdata32;
  wire  [63:0]      rdata64;

  data_mem_ctrl #(.XLEN(32), .ADDRESS_WIDTH(16), .DATA_WIDTH(8), .LATENCY(LAT0)) u_d32 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready_w[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0][31:0]), .req_wdata(req_wdata[0][31:0]), .req_funct3(req_funct3[0]),
    .rsp_valid(rsp_valid_w[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rdata32),
    .rsp_fault(rsp_fault_w[0]));

  data_mem_ctrl #(.XLEN(64), .ADDRESS_WIDTH(16), .DATA_WIDTH(8), .LATENCY(LAT1)) u_d64 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready_w[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_funct3(req_funct3[1]),
    .rsp_valid(rsp_valid_w[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rdata64),
    .rsp_fault(rsp_fault_w[1]));

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit [63:0] rd;
    bit        flt;
    int        acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  bit [7:0] mm[int];
  bit [1:0] force_stall = 2'b00;

  function automatic logic [63:0] rdata_of(int d);
    return (d == 0) ? {32'b0, rdata32} : rdata64;
  endfunction

  function automatic int lat_of(int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: byte map per controller, size from funct3, extension by
  // arithmetic on the assembled little-endian value.
  function automatic void model(int d, bit we, bit [63:0] addr, bit [63:0] wd,
                                bit [2:0] f3, output bit [63:0] rd, output bit flt);
    int xb = (d == 0) ? 4 : 8;
    int sz = 1 << f3[1:0];
    int base = int'(addr[15:0]);
    bit [63:0] v = 0;
    flt = (f3 == 3'd7) || (d == 0 && (f3 == 3'd3 || f3 == 3'd6)) || (we && f3[2]);
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((base % sz) != 0) flt = 1'b1;
`endif
    rd = 0;
    if (flt) return;
    for (int i = 0; i < sz; i++) begin
      int key = d * 65536 + ((base + i) % 65536);
      if (we) mm[key] = wd[8*i +: 8];
      else if (mm.exists(key)) v = v | (64'(mm[key]) << (8 * i));
    end
    if (!we) begin
      if (!f3[2] && sz < xb && v[8*sz-1]) v = v | ~((64'd1 << (8 * sz)) - 64'd1);
      if (xb == 4) v = v & 64'hFFFF_FFFF;
      rd = v;
    end
  endfunction

  task automatic issue(int d, bit we, bit [63:0] addr, bit [63:0] wd, bit [2:0] f3);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!req_ready_w[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_w[d]) begin
      chk("req_ready_timeout", {63'b0, req_ready_w[d]}, 64'd1);
      return;
    end
    model(d, we, addr, wd, f3, e.rd, e.flt);
    e.acc = cyc;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
    req_wdata[d] = wd; req_funct3[d] = f3;
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_addr[d] = {$urandom, $urandom};
    req_wdata[d] = {$urandom, $urandom};
    req_funct3[d] = 3'($urandom_range(0, 7));
    chk("req_ready_after_accept", {63'b0, req_ready_w[d]}, 64'd0);
  endtask

  task automatic monitor(int d);
    bit        active = 1'b0;
    int        stall = 0;
    bit [63:0] held = 0;
    bit        hf = 1'b0;
    exp_t      e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
        rsp_ready[d] = 1'b0;
      end else if (rsp_valid_w[d]) begin
        if (!active) begin
          active = 1'b1;
          if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            chk("unexpected_rsp", 64'd1, 64'd0);
            e.rd = rdata_of(d); e.flt = rsp_fault_w[d]; e.acc = 0;
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk("rsp_rdata", rdata_of(d), e.rd);
            chk("rsp_fault", {63'b0, rsp_fault_w[d]}, {63'b0, e.flt});
            chk("rsp_latency", 64'(cyc), 64'(e.acc + 1 + lat_of(d)));
          end
          held = e.rd;
          hf = e.flt;
          stall = force_stall[d] ? 4 : $urandom_range(0, 3);
          force_stall[d] = 1'b0;
        end else begin
          chk("stall_rdata_stable", rdata_of(d), held);
          chk("stall_fault_stable", {63'b0, rsp_fault_w[d]}, {63'b0, hf});
        end
        chk("req_ready_in_resp", {63'b0, req_ready_w[d]}, 64'd0);
        if (stall > 0) begin
          rsp_ready[d] = 1'b0;
          stall--;
        end else begin
          rsp_ready[d] = 1'b1;
        end
      end else begin
        active = 1'b0;
        rsp_ready[d] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || rsp_valid_w != 2'b00) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(q0.size() + q1.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic rand_ops(int d, int count);
    for (int k = 0; k < count; k++) begin
      bit [63:0] a = {$urandom, $urandom};
      bit [15:0] lo = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF))
                                                  : 16'($urandom_range(0, 16'h0078));
      a[15:0] = lo;
      issue(d, 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 3'($urandom_range(0, 7)));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_we = '0; rsp_ready = '0;
    req_addr = '0; req_wdata = '0; req_funct3 = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_req_ready", {63'b0, req_ready_w[d]}, 64'd1);
      chk("reset_rsp_valid", {63'b0, rsp_valid_w[d]}, 64'd0);
      chk("reset_rsp_rdata", rdata_of(d), 64'd0);
      chk("reset_rsp_fault", {63'b0, rsp_fault_w[d]}, 64'd0);
    end
    rst_n = 1'b1;
    fork
      monitor(0);
      monitor(1);
    join_none

    // Known contents for the regions random traffic touches.
    for (int a = 0; a < 128; a += 4) issue(0, 1'b1, 64'(a), {$urandom, $urandom}, 3'd2);
    for (int a = 16'hFFF0; a < 65536; a += 4) issue(0, 1'b1, 64'(a), {$urandom, $urandom}, 3'd2);
    for (int a = 0; a < 128; a += 8) issue(1, 1'b1, 64'(a), {$urandom, $urandom}, 3'd3);
    for (int a = 16'hFFF0; a < 65536; a += 8) issue(1, 1'b1, 64'(a), {$urandom, $urandom}, 3'd3);

    // XLEN=32 directed sequence
    issue(0, 1'b1, 64'h10, 64'hDEADBEEF, 3'd2);
    issue(0, 1'b0, 64'h10, 64'h0, 3'd2);
    issue(0, 1'b0, 64'h13, 64'h0, 3'd0);
    issue(0, 1'b0, 64'h13, 64'h0, 3'd4);
    issue(0, 1'b0, 64'h10, 64'h0, 3'd1);
    issue(0, 1'b0, 64'h10, 64'h0, 3'd5);
    issue(0, 1'b1, 64'h11, 64'h55, 3'd0);
    issue(0, 1'b0, 64'h10, 64'h0, 3'd2);
    issue(0, 1'b1, 64'hFFFE, 64'hA1B2C3D4, 3'd2);
    issue(0, 1'b0, 64'h0001, 64'h0, 3'd4);
    issue(0, 1'b1, 64'h21, 64'hFFFF, 3'd1);
    issue(0, 1'b0, 64'h20, 64'h0, 3'd2);
    issue(0, 1'b0, 64'h20, 64'h0, 3'd3);
    issue(0, 1'b0, 64'h20, 64'h0, 3'd6);
    issue(0, 1'b1, 64'h20, 64'h1234, 3'd4);
    issue(0, 1'b0, 64'h20, 64'h0, 3'd7);
    issue(0, 1'b0, 64'h20, 64'h0, 3'd2);

    // XLEN=64 directed sequence, first response stalled four cycles
    drain();
    force_stall[1] = 1'b1;
    issue(1, 1'b1, 64'h40, 64'h8000_0000_1234_5678, 3'd3);
    issue(1, 1'b0, 64'h44, 64'h0, 3'd6);
    issue(1, 1'b0, 64'h40, 64'h0, 3'd3);
    issue(1, 1'b0, 64'h44, 64'h0, 3'd2);
    issue(1, 1'b0, 64'h40, 64'h0, 3'd7);
    issue(1, 1'b1, 64'h40, 64'h0, 3'd6);

    // Reset while BUSY: the store must be dropped and outputs cleared at once.
    drain();
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 64'h40;
    req_wdata[1] = 64'h1111_2222_3333_4444; req_funct3[1] = 3'd3;
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_req_ready", {63'b0, req_ready_w[1]}, 64'd1);
    chk("abort_rsp_valid", {63'b0, rsp_valid_w[1]}, 64'd0);
    chk("abort_rsp_rdata", rdata64, 64'd0);
    chk("abort_rsp_fault", {63'b0, rsp_fault_w[1]}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(1, 1'b0, 64'h40, 64'h0, 3'd3);
    issue(1, 1'b0, 64'h44, 64'h0, 3'd2);

    rand_ops(0, 150);
    rand_ops(1, 150);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
